// File: rtl/scan_seq_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Holds the FSM state encoding, channel geometry and the lowest-set-bit helper.
package scan_seq_pkg;

  localparam int SEL_W = 4;
  localparam int NCH   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SCAN    = 3'd2,
    ST_GAP_OFF = 3'd3,
    ST_GAP_SEL = 3'd4
  } state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = {SEL_W{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_sequencer_chan_search.sv
// Combinational channel search: next enabled channel above the current select,
// with wrap detection, plus the lowest enabled channel and an any-enabled flag.
module chan_search
  import scan_seq_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] next_idx,
  output logic             wrap,
  output logic [SEL_W-1:0] low_idx,
  output logic             any_set
);

  logic [NCH-1:0] above_s;

  assign above_s = mask & ({NCH{1'b1}} << (32'(sel) + 32'd1));
  assign low_idx = lowest_set(mask);
  assign any_set = |mask;

  // Pick the next channel above sel, or wrap back to the lowest enabled one.
  always_comb begin
    next_idx = low_idx;
    wrap     = 1'b1;
    if (|above_s) begin
      next_idx = lowest_set(above_s);
      wrap     = 1'b0;
    end else begin
      next_idx = low_idx;
      wrap     = 1'b1;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer driving the 4-to-16 decoder: steps sel through enabled channels
// with a programmable enable dwell and a two-cycle enable-low gap around each change.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH-1:0]     ch_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done
);

  state_e             state_r;
  logic [NCH-1:0]     mask_sh_r;
  logic [DWELL_W-1:0] dwell_sh_r;
  logic               mode_sh_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [SEL_W-1:0]   sel_r;
  logic               en_r;
  logic               busy_r;
  logic               done_r;

  logic [NCH-1:0]     search_mask_s;
  logic [SEL_W-1:0]   next_s;
  logic               wrap_s;
  logic [SEL_W-1:0]   low_s;
  logic               any_s;
  logic [DWELL_W-1:0] load_s;

  // In IDLE the live mask is searched for the first channel; otherwise the shadow.
  assign search_mask_s = (state_r == ST_IDLE) ? ch_mask : mask_sh_r;

  // Counter counts down to zero, so a dwell of 0 behaves like 1.
  assign load_s = (dwell_sh_r == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                  : (dwell_sh_r - DWELL_W'(1));

  chan_search u_chan_search (
    .mask     (search_mask_s),
    .sel      (sel_r),
    .next_idx (next_s),
    .wrap     (wrap_s),
    .low_idx  (low_s),
    .any_set  (any_s)
  );

  // Scan FSM, dwell counter, shadow capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mask_sh_r  <= {NCH{1'b0}};
      dwell_sh_r <= {DWELL_W{1'b0}};
      mode_sh_r  <= 1'b0;
      cnt_r      <= {DWELL_W{1'b0}};
      sel_r      <= {SEL_W{1'b0}};
      en_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (stop && (state_r != ST_IDLE)) begin
        en_r    <= 1'b0;
        busy_r  <= 1'b0;
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start && !stop && any_s) begin
              mask_sh_r  <= ch_mask;
              dwell_sh_r <= dwell;
              mode_sh_r  <= mode_cont;
              sel_r      <= low_s;
              busy_r     <= 1'b1;
              state_r    <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            en_r    <= 1'b1;
            cnt_r   <= load_s;
            state_r <= ST_SCAN;
          end
          ST_SCAN: begin
            if (cnt_r == {DWELL_W{1'b0}}) begin
              en_r <= 1'b0;
              if (wrap_s) begin
                done_r <= 1'b1;
                if (mode_sh_r) begin
                  state_r <= ST_GAP_OFF;
                end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
                end
              end else begin
                state_r <= ST_GAP_OFF;
              end
            end else begin
              cnt_r <= cnt_r - DWELL_W'(1);
            end
          end
          ST_GAP_OFF: begin
            sel_r   <= next_s;
            state_r <= ST_GAP_SEL;
          end
          ST_GAP_SEL: begin
            en_r    <= 1'b1;
            cnt_r   <= load_s;
            state_r <= ST_SCAN;
          end
          default: begin
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sel  = sel_r;
  assign en   = en_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: vector table, directed multi-cycle
// sequences and randomized scans against a sweep-level reference model.
module tb_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        mode_cont;
  logic [7:0]  dwell;
  logic [15:0] ch_mask;
  logic [3:0]  sel;
  logic        en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] mask;
    logic [7:0]  dwell;
    obs_t        exp;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[17];

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .dwell     (dwell),
    .ch_mask   (ch_mask),
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input obs_t exp);
    obs_t act;
    act = {sel, en, busy, done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got sel=%0d en=%0b busy=%0b done=%0b, expected sel=%0d en=%0b busy=%0b done=%0b",
               name, k, act.sel, act.en, act.busy, act.done, exp.sel, exp.en, exp.busy, exp.done);
    end
  endtask

  function automatic vec_t mkv(input logic st, input logic sp, input logic md,
                               input logic [15:0] m, input logic [7:0] dw,
                               input logic [3:0] s, input logic e, input logic b,
                               input logic dn);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.mask = m; v.dwell = dw;
    v.exp = {s, e, b, dn};
    return v;
  endfunction

  // Expected outputs after edges 0..n-1, where edge 0 samples start.
  task automatic gen(input logic [15:0] m, input logic [7:0] dw, input logic md, input int n);
    int chans[$];
    int d;
    int j;
    bit last;
    exp_q.delete();
    d = (dw == 8'd0) ? 1 : int'(dw);
    for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
    exp_q.push_back({4'(chans[0]), 1'b0, 1'b1, 1'b0});
    j = 0;
    while (exp_q.size() < n) begin
      for (int r = 0; r < d; r++) exp_q.push_back({4'(chans[j]), 1'b1, 1'b1, 1'b0});
      last = (j == chans.size() - 1);
      if (last && !md) begin
        exp_q.push_back({4'(chans[j]), 1'b0, 1'b0, 1'b1});
        while (exp_q.size() < n) exp_q.push_back({4'(chans[j]), 1'b0, 1'b0, 1'b0});
      end else begin
        exp_q.push_back({4'(chans[j]), 1'b0, 1'b1, last});
        j = last ? 0 : j + 1;
        exp_q.push_back({4'(chans[j]), 1'b0, 1'b1, 1'b0});
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] m, input logic [7:0] dw, input logic md,
                          input int n, input int stop_idx, input bit perturb, input string name);
    obs_t exp;
    obs_t hold;
    bit   stopped;
    gen(m, dw, md, n);
    stopped = 1'b0;
    hold = '0;
    ch_mask = m; dwell = dw; mode_cont = md;
    for (int k = 0; k < n; k++) begin
      start = (k == 0);
      stop  = (k == stop_idx);
      if (perturb && k == 3) begin
        ch_mask = 16'h0001;
        dwell   = 8'd7;
        start   = 1'b1;
      end
      @(posedge clk);
      #1;
      if (stopped) begin
        exp = hold;
      end else if (k == stop_idx && k > 0 && exp_q[k-1].busy) begin
        exp = {exp_q[k-1].sel, 1'b0, 1'b0, 1'b0};
        hold = exp;
        stopped = 1'b1;
      end else begin
        exp = exp_q[k];
      end
      check(name, k, exp);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rm;
    logic [7:0]  rd;
    logic        rmd;
    int          n;
    int          sidx;
    int          pc;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    dwell = 8'd0; ch_mask = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 7'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_idle", 0, 7'b0);

    vecs[0]  = mkv(1, 1, 0, 16'h0005, 8'd3, 4'd0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 16'h0000, 8'd3, 4'd0, 0, 0, 0);
    vecs[2]  = mkv(1, 0, 0, 16'h0005, 8'd3, 4'd0, 0, 1, 0);
    vecs[3]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd0, 1, 1, 0);
    vecs[4]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd0, 1, 1, 0);
    vecs[5]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd0, 1, 1, 0);
    vecs[6]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd0, 0, 1, 0);
    vecs[7]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 0, 1, 0);
    vecs[8]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 1, 1, 0);
    vecs[9]  = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 1, 1, 0);
    vecs[10] = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 1, 1, 0);
    vecs[11] = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 0, 0, 1);
    vecs[12] = mkv(0, 0, 0, 16'h0005, 8'd3, 4'd2, 0, 0, 0);
    vecs[13] = mkv(1, 0, 0, 16'h0010, 8'd0, 4'd4, 0, 1, 0);
    vecs[14] = mkv(0, 0, 0, 16'h0010, 8'd0, 4'd4, 1, 1, 0);
    vecs[15] = mkv(0, 0, 0, 16'h0010, 8'd0, 4'd4, 0, 0, 1);
    vecs[16] = mkv(0, 0, 0, 16'h0010, 8'd0, 4'd4, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; mode_cont = vecs[i].mode;
      ch_mask = vecs[i].mask; dwell = vecs[i].dwell;
      @(posedge clk);
      #1;
      check("table", i, vecs[i].exp);
    end
    start = 1'b0; stop = 1'b0;

    run_scan(16'h8001, 8'd1, 1'b1, 20, 19, 1'b0, "cont_8001");
    run_scan(16'hFFFF, 8'd2, 1'b1, 24, 23, 1'b0, "stop_ch5");
    run_scan(16'h0006, 8'd2, 1'b0, 11, -1, 1'b1, "shadow");

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) rm = 16'h0001 << $urandom_range(0, 15);
      else rm = 16'($urandom_range(1, 65535));
      rd  = 8'($urandom_range(0, 4));
      rmd = 1'($urandom_range(0, 1));
      pc = $countones(rm);
      if (rmd) begin
        n = $urandom_range(6, 70);
        sidx = n - 1;
      end else begin
        n = 1 + pc * (((rd == 8'd0) ? 1 : int'(rd)) + 2) + 1;
        sidx = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      end
      run_scan(rm, rd, rmd, n, sidx, 1'b0, "random");
    end

    ch_mask = 16'hFFF0; dwell = 8'd5; mode_cont = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_scan", 0, {4'd4, 1'b1, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 7'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 0, 7'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
